// File: rtl/load_reply_unit_pkg.sv
// Shared definitions for the load reply unit: reply reasons, the reply request
// bundle and a saturating-counter helper used by the optional perf counters.
package load_reply_unit_pkg;

    localparam logic [1:0] REPLY_BANK      = 2'b00;
    localparam logic [1:0] REPLY_MISS_WAIT = 2'b00;
    localparam logic [1:0] REPLY_FWD       = 2'b01;
    localparam logic [1:0] REPLY_MSHR      = 2'b10;
    localparam logic [1:0] REPLY_TLB       = 2'b11;

    localparam int unsigned ReplyIdxW = 4;

    typedef struct packed {
        logic                 fast_en;
        logic [ReplyIdxW-1:0] fast_idx;
        logic                 slow_en;
        logic [ReplyIdxW-1:0] slow_idx;
        logic [1:0]           slow_reason;
        logic                 success;
        logic [ReplyIdxW-1:0] success_idx;
    } ReplyRequest;

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt, input logic en);
        return (en && (cnt != 16'hFFFF)) ? cnt + 16'd1 : cnt;
    endfunction

endpackage

// File: rtl/load_reply_age_kill.sv
// Combinational ROB age compare and flush-kill decision for one pipeline stage.
module load_reply_age_kill #(
    parameter int unsigned ROB_W = 6
) (
    input  logic           valid_i,
    input  logic [ROB_W:0] rob_idx_i,
    input  logic           redirect_i,
    input  logic [ROB_W:0] redirect_idx_i,
    output logic           kill_o
);

    logic older;

    // Strictly older only; an equal ROB index is on the flushed side.
    assign older  = (rob_idx_i[ROB_W] ^ redirect_idx_i[ROB_W]) ^
                    (rob_idx_i[ROB_W-1:0] < redirect_idx_i[ROB_W-1:0]);
    assign kill_o = valid_i & redirect_i & ~older;

endmodule

// File: rtl/load_reply_unit.sv
// Per-load-pipeline reply generator: fast reply from S1, slow reply or success from S3.
// Optional LOAD_REPLY_PERF_EN adds 16-bit saturating reply counters.
module load_reply_unit
    import load_reply_unit_pkg::*;
#(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned ROB_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_en_i,
    input  logic [IDX_W-1:0] issue_idx_i,
    input  logic [ROB_W:0]   issue_rob_idx_i,
    input  logic             issue_exception_i,
    input  logic             s1_dcache_ready_i,
    input  logic             s2_tlb_miss_i,
    input  logic             s2_fwd_wait_i,
    input  logic             s3_hit_i,
    input  logic             s3_mshr_full_i,
    input  logic             redirect_i,
    input  logic [ROB_W:0]   redirect_idx_i,
    output logic             reply_fast_en_o,
    output logic [IDX_W-1:0] reply_fast_idx_o,
    output logic             reply_slow_en_o,
    output logic [IDX_W-1:0] reply_slow_idx_o,
    output logic [1:0]       reply_slow_reason_o,
    output logic             success_o,
    output logic [IDX_W-1:0] success_idx_o
`ifdef LOAD_REPLY_PERF_EN
    ,
    output logic [15:0]      perf_fast_cnt_o,
    output logic [15:0]      perf_tlb_cnt_o,
    output logic [15:0]      perf_fwd_cnt_o,
    output logic [15:0]      perf_miss_cnt_o
`endif
);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic [ROB_W:0]   rob_idx;
        logic             exc;
        logic             tlbmiss;
        logic             fwd;
    } stage_t;

    stage_t s1, s2_d, s2_q, s3_d, s3_q;
    logic   s1_kill, s2_kill, s3_kill;

    logic             fast_en_d, fast_en_q;
    logic [IDX_W-1:0] fast_idx_d, fast_idx_q;
    logic             slow_en_d, slow_en_q;
    logic [IDX_W-1:0] slow_idx_d, slow_idx_q;
    logic [1:0]       slow_reason_d, slow_reason_q;
    logic             success_d, success_q;
    logic [IDX_W-1:0] success_idx_d, success_idx_q;

    load_reply_age_kill #(.ROB_W(ROB_W)) u_kill_s1 (
        .valid_i        (s1.valid),
        .rob_idx_i      (s1.rob_idx),
        .redirect_i     (redirect_i),
        .redirect_idx_i (redirect_idx_i),
        .kill_o         (s1_kill)
    );

    load_reply_age_kill #(.ROB_W(ROB_W)) u_kill_s2 (
        .valid_i        (s2_q.valid),
        .rob_idx_i      (s2_q.rob_idx),
        .redirect_i     (redirect_i),
        .redirect_idx_i (redirect_idx_i),
        .kill_o         (s2_kill)
    );

    load_reply_age_kill #(.ROB_W(ROB_W)) u_kill_s3 (
        .valid_i        (s3_q.valid),
        .rob_idx_i      (s3_q.rob_idx),
        .redirect_i     (redirect_i),
        .redirect_idx_i (redirect_idx_i),
        .kill_o         (s3_kill)
    );

    always_comb begin
        s1         = '0;
        s1.valid   = issue_en_i;
        s1.idx     = issue_idx_i;
        s1.rob_idx = issue_rob_idx_i;
        s1.exc     = issue_exception_i;

        // Exception loads skip the dcache, so a refused request does not bounce them.
        fast_en_d  = s1.valid & ~s1_kill & ~s1.exc & ~s1_dcache_ready_i;
        fast_idx_d = fast_en_d ? s1.idx : '0;
        s2_d       = s1;
        s2_d.valid = s1.valid & ~s1_kill & (s1.exc | s1_dcache_ready_i);

        s3_d         = s2_q;
        s3_d.valid   = s2_q.valid & ~s2_kill;
        s3_d.tlbmiss = s2_tlb_miss_i & ~s2_q.exc;
        s3_d.fwd     = s2_fwd_wait_i & ~s2_q.exc;

        slow_en_d     = 1'b0;
        slow_idx_d    = '0;
        slow_reason_d = REPLY_BANK;
        success_d     = 1'b0;
        success_idx_d = '0;
        if (s3_q.valid && !s3_kill) begin
            if (s3_q.exc || (!s3_q.tlbmiss && !s3_q.fwd && s3_hit_i)) begin
                success_d     = 1'b1;
                success_idx_d = s3_q.idx;
            end else begin
                slow_en_d  = 1'b1;
                slow_idx_d = s3_q.idx;
                if (s3_q.tlbmiss)       slow_reason_d = REPLY_TLB;
                else if (s3_q.fwd)      slow_reason_d = REPLY_FWD;
                else if (s3_mshr_full_i) slow_reason_d = REPLY_MSHR;
                else                    slow_reason_d = REPLY_MISS_WAIT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_q          <= '0;
            s3_q          <= '0;
            fast_en_q     <= 1'b0;
            fast_idx_q    <= '0;
            slow_en_q     <= 1'b0;
            slow_idx_q    <= '0;
            slow_reason_q <= '0;
            success_q     <= 1'b0;
            success_idx_q <= '0;
        end else begin
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            fast_en_q     <= fast_en_d;
            fast_idx_q    <= fast_idx_d;
            slow_en_q     <= slow_en_d;
            slow_idx_q    <= slow_idx_d;
            slow_reason_q <= slow_reason_d;
            success_q     <= success_d;
            success_idx_q <= success_idx_d;
        end
    end

    assign reply_fast_en_o     = fast_en_q;
    assign reply_fast_idx_o    = fast_idx_q;
    assign reply_slow_en_o     = slow_en_q;
    assign reply_slow_idx_o    = slow_idx_q;
    assign reply_slow_reason_o = slow_reason_q;
    assign success_o           = success_q;
    assign success_idx_o       = success_idx_q;

`ifdef LOAD_REPLY_PERF_EN
    logic [15:0] perf_fast_q, perf_tlb_q, perf_fwd_q, perf_miss_q;
    logic        miss_reply;

    assign miss_reply = slow_en_d &
                        ((slow_reason_d == REPLY_MSHR) || (slow_reason_d == REPLY_MISS_WAIT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fast_q <= '0;
            perf_tlb_q  <= '0;
            perf_fwd_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            perf_fast_q <= sat_inc16(perf_fast_q, fast_en_d);
            perf_tlb_q  <= sat_inc16(perf_tlb_q, slow_en_d & (slow_reason_d == REPLY_TLB));
            perf_fwd_q  <= sat_inc16(perf_fwd_q, slow_en_d & (slow_reason_d == REPLY_FWD));
            perf_miss_q <= sat_inc16(perf_miss_q, miss_reply);
        end
    end

    assign perf_fast_cnt_o = perf_fast_q;
    assign perf_tlb_cnt_o  = perf_tlb_q;
    assign perf_fwd_cnt_o  = perf_fwd_q;
    assign perf_miss_cnt_o = perf_miss_q;
`endif

endmodule

// File: tb/tb_load_reply_unit.sv
// Directed bench for load_reply_unit: expected replies are queued with their due cycle
// and every cycle's outputs are compared against whatever the queue says is due.
module tb_load_reply_unit;
    import load_reply_unit_pkg::*;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned ROB_W = 6;
    localparam int KFast = 0;
    localparam int KSlow = 1;
    localparam int KSucc = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_en;
    logic [IDX_W-1:0] issue_idx;
    logic [ROB_W:0]   issue_rob_idx;
    logic             issue_exception;
    logic             s1_dcache_ready;
    logic             s2_tlb_miss;
    logic             s2_fwd_wait;
    logic             s3_hit;
    logic             s3_mshr_full;
    logic             redirect;
    logic [ROB_W:0]   redirect_idx;
    logic             reply_fast_en;
    logic [IDX_W-1:0] reply_fast_idx;
    logic             reply_slow_en;
    logic [IDX_W-1:0] reply_slow_idx;
    logic [1:0]       reply_slow_reason;
    logic             success;
    logic [IDX_W-1:0] success_idx;
`ifdef LOAD_REPLY_PERF_EN
    logic [15:0]      perf_fast_cnt, perf_tlb_cnt, perf_fwd_cnt, perf_miss_cnt;
`endif

    always #5 clk = ~clk;

    load_reply_unit #(.IDX_W(IDX_W), .ROB_W(ROB_W)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .issue_en_i          (issue_en),
        .issue_idx_i         (issue_idx),
        .issue_rob_idx_i     (issue_rob_idx),
        .issue_exception_i   (issue_exception),
        .s1_dcache_ready_i   (s1_dcache_ready),
        .s2_tlb_miss_i       (s2_tlb_miss),
        .s2_fwd_wait_i       (s2_fwd_wait),
        .s3_hit_i            (s3_hit),
        .s3_mshr_full_i      (s3_mshr_full),
        .redirect_i          (redirect),
        .redirect_idx_i      (redirect_idx),
        .reply_fast_en_o     (reply_fast_en),
        .reply_fast_idx_o    (reply_fast_idx),
        .reply_slow_en_o     (reply_slow_en),
        .reply_slow_idx_o    (reply_slow_idx),
        .reply_slow_reason_o (reply_slow_reason),
        .success_o           (success),
        .success_idx_o       (success_idx)
`ifdef LOAD_REPLY_PERF_EN
        ,
        .perf_fast_cnt_o     (perf_fast_cnt),
        .perf_tlb_cnt_o      (perf_tlb_cnt),
        .perf_fwd_cnt_o      (perf_fwd_cnt),
        .perf_miss_cnt_o     (perf_miss_cnt)
`endif
    );

    typedef struct {
        int unsigned      cyc;
        int               kind;
        logic [IDX_W-1:0] idx;
        logic [1:0]       reason;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;

    logic [16:0] obs_v, exp_v;
    logic             e_fe, e_se, e_su;
    logic [IDX_W-1:0] e_fi, e_si, e_ui;
    logic [1:0]       e_sr;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            e_fe = 1'b0; e_fi = '0; e_se = 1'b0; e_si = '0; e_sr = '0; e_su = 1'b0; e_ui = '0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    case (sb[i].kind)
                        KFast:   begin e_fe = 1'b1; e_fi = sb[i].idx; end
                        KSlow:   begin e_se = 1'b1; e_si = sb[i].idx; e_sr = sb[i].reason; end
                        default: begin e_su = 1'b1; e_ui = sb[i].idx; end
                    endcase
                    sb.delete(i);
                end
            end
            obs_v = {reply_fast_en, reply_fast_idx, reply_slow_en, reply_slow_idx,
                     reply_slow_reason, success, success_idx};
            exp_v = {e_fe, e_fi, e_se, e_si, e_sr, e_su, e_ui};
            checks++;
            assert (obs_v === exp_v) else begin
                errors++;
                $error("FAIL outputs@cyc%0d observed={fe,fi,se,si,sr,su,ui}=%b expected=%b",
                       cyc, obs_v, exp_v);
            end
        end
    end

    task automatic defaults();
        rst = 1'b0; issue_en = 1'b0; issue_idx = '0; issue_rob_idx = '0;
        issue_exception = 1'b0; s1_dcache_ready = 1'b1; s2_tlb_miss = 1'b0;
        s2_fwd_wait = 1'b0; s3_hit = 1'b1; s3_mshr_full = 1'b0;
        redirect = 1'b0; redirect_idx = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        defaults();
    endtask

    task automatic issue(input logic [IDX_W-1:0] idx, input logic [ROB_W:0] rob,
                         input logic exc, input logic rdy);
        issue_en = 1'b1; issue_idx = idx; issue_rob_idx = rob;
        issue_exception = exc; s1_dcache_ready = rdy;
    endtask

    task automatic expect_ev(input int unsigned at, input int kind,
                             input logic [IDX_W-1:0] idx, input logic [1:0] reason);
        exp_t e;
        e.cyc = at; e.kind = kind; e.idx = idx; e.reason = reason;
        sb.push_back(e);
    endtask

    int unsigned t;

    initial begin
        defaults();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        defaults();

        // Fast reply: dcache refuses, load must not reach S3.
        t = cyc;
        issue(4'd5, 7'd10, 1'b0, 1'b0);
        expect_ev(t + 1, KFast, 4'd5, 2'b00);
        repeat (4) tick();

        // DTLB miss -> slow, reason TLB.
        t = cyc;
        issue(4'd3, 7'd11, 1'b0, 1'b1);
        expect_ev(t + 3, KSlow, 4'd3, REPLY_TLB);
        tick(); s2_tlb_miss = 1'b1;
        repeat (4) tick();

        // Forward wait beats MSHR-full miss.
        t = cyc;
        issue(4'd2, 7'd12, 1'b0, 1'b1);
        expect_ev(t + 3, KSlow, 4'd2, REPLY_FWD);
        tick(); s2_fwd_wait = 1'b1;
        tick(); s3_hit = 1'b0; s3_mshr_full = 1'b1;
        repeat (3) tick();

        // Exception load completes even with a TLB miss and a refused dcache.
        t = cyc;
        issue(4'd1, 7'd13, 1'b1, 1'b0);
        expect_ev(t + 3, KSucc, 4'd1, 2'b00);
        tick(); s2_tlb_miss = 1'b1;
        tick(); s3_hit = 1'b0; s3_mshr_full = 1'b1;
        repeat (3) tick();

        // MSHR-full and plain miss back to back, plus a fast reply alongside the slow one.
        t = cyc;
        issue(4'd6, 7'd14, 1'b0, 1'b1);
        expect_ev(t + 3, KSlow, 4'd6, REPLY_MSHR);
        expect_ev(t + 4, KSlow, 4'd7, REPLY_MISS_WAIT);
        expect_ev(t + 3, KFast, 4'd4, 2'b00);
        tick(); issue(4'd7, 7'd15, 1'b0, 1'b1);
        tick(); s3_hit = 1'b0; s3_mshr_full = 1'b1; issue(4'd4, 7'd16, 1'b0, 1'b0);
        tick(); s3_hit = 1'b0;
        repeat (3) tick();

        // Redirect at rob 8: rob 7 (S3) survives, rob 9 (S2) and rob 12 (S1) are killed.
        t = cyc;
        issue(4'd8, 7'd7, 1'b0, 1'b1);
        expect_ev(t + 3, KSucc, 4'd8, 2'b00);
        tick(); issue(4'd9, 7'd9, 1'b0, 1'b1);
        tick(); issue(4'd10, 7'd12, 1'b0, 1'b0); redirect = 1'b1; redirect_idx = 7'd8;
        repeat (4) tick();

        // Wrap: redirect {1,2}; rob {0,7} is older, equal rob {1,2} is killed.
        t = cyc;
        issue(4'd11, 7'h07, 1'b0, 1'b1);
        expect_ev(t + 3, KSucc, 4'd11, 2'b00);
        tick(); issue(4'd12, 7'h42, 1'b0, 1'b1);
        tick(); redirect = 1'b1; redirect_idx = 7'h42;
        repeat (4) tick();

        // S3 kill: rob 20 is younger than redirect 15.
        issue(4'd13, 7'd20, 1'b0, 1'b1);
        tick();
        tick(); redirect = 1'b1; redirect_idx = 7'd15;
        repeat (3) tick();

        // Back-to-back hits on idx 0..3.
        t = cyc;
        for (int i = 0; i < 4; i++) begin
            issue(4'(i), 7'(30 + i), 1'b0, 1'b1);
            expect_ev(t + 3 + i, KSucc, 4'(i), 2'b00);
            tick();
        end
        repeat (5) tick();

        // Reset mid-flight drops the load with no reply.
        issue(4'd14, 7'd40, 1'b0, 1'b1);
        tick(); rst = 1'b1;
        tick();
        t = cyc;
        issue(4'd15, 7'd41, 1'b0, 1'b0);
        expect_ev(t + 1, KFast, 4'd15, 2'b00);
        repeat (5) tick();

        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_reply_unit.md
# load_reply_unit

Per-load-pipeline reply generator: the responder side of the load issue queue's replay protocol. It tracks each issued load through pipeline stages S1–S3 and returns exactly one outcome per surviving load to the issuing bank. The outcome is a fast reply, a slow reply with a reason, or success. One instance sits in each load pipeline, between the load issue queue and the DTLB/dcache/store-forward logic.

## Interface
- IDX_W, default 4: issue-bank index width (`LOAD_ISSUE_BANK_WIDTH`).
- ROB_W, default 6: ROB index width, excluding the dir bit.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- issue_en  in  1  load enters S1 this cycle.
- issue_idx  in  IDX_W  issue-bank slot of the load.
- issue_rob_idx  in  ROB_W+1  {dir, idx}.
- issue_exception  in  1  slot already holds a TLB exception; the load must complete without a dcache access.
- s1_dcache_ready  in  1  dcache accepted the S1 request.
- s2_tlb_miss  in  1  DTLB miss for the S2 load.
- s2_fwd_wait  in  1  older store address matches but its data is not ready.
- s3_hit  in  1  dcache hit in S3.
- s3_mshr_full  in  1  miss could not allocate an MSHR.
- redirect  in  1  backend flush.
- redirect_idx  in  ROB_W+1  flush boundary.
- reply_fast_en  out  1  fast reply valid.
- reply_fast_idx  out  IDX_W  slot being replied to.
- reply_slow_en  out  1  slow reply valid.
- reply_slow_idx  out  IDX_W  slot being replied to.
- reply_slow_reason  out  2  replay reason.
- success  out  1  load retired from the issue slot.
- success_idx  out  IDX_W  slot to free.

## Operation
- Stage registers s1/s2/s3 each hold {valid, idx, rob_idx, exc, tlbmiss, fwd}.
- s2 and s3 advance every cycle; the pipeline never stalls.
- Fast path: when S1 is valid, not killed, not exc, and s1_dcache_ready=0, raise reply_fast with idx. The load does not enter S2.
- S2:
  - latch tlbmiss = s2_tlb_miss & ~exc.
  - latch fwd = s2_fwd_wait & ~exc.
- S3 priority, exactly one result per load:
  - exc → success.
  - tlbmiss → slow, reason 2'b11.
  - fwd → slow, reason 2'b01.
  - ~s3_hit & s3_mshr_full → slow, reason 2'b10.
  - ~s3_hit otherwise → slow, reason 2'b00 (wait for refill).
  - hit → success.
- Kill rule: a stage is killed when redirect=1 and its rob_idx is not strictly older than redirect_idx. Age is computed as (dir ^ rdir) ^ (idx < ridx); an equal index counts as killed.
- A killed stage produces no output and clears its valid bit.

## Timing
- A load issued at cycle T occupies S1 at T, S2 at T+1, S3 at T+2.
- reply_fast is registered and visible at T+1.
- reply_slow and success are registered and visible at T+3.
- Every output is a 1-cycle pulse.
- Fast and slow outputs can assert in the same cycle for different loads; the bank accepts both ports.
- A redirect at cycle C suppresses every output that would become visible at C+1 for killed loads. Outputs already visible at C are not retracted.
- Reset: all stage valids are 0. reply_fast_en, reply_slow_en and success are 0. All idx/reason outputs are 0.
- Reset applied mid-flight drops in-flight loads without a reply; the issue queue resets concurrently.
- ROB wrap-around is handled only through the dir bit. No other age state exists.

## Configuration
- LOAD_REPLY_PERF_EN defined: adds outputs perf_fast_cnt, perf_tlb_cnt, perf_fwd_cnt and perf_miss_cnt. Each is a 16 bit saturating counter that increments on the matching reply and is cleared by rst.
- LOAD_REPLY_PERF_EN undefined: those ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package holds:
  - the reply-reason localparams REPLY_BANK/MISS_WAIT = 2'b00, REPLY_FWD = 2'b01, REPLY_MSHR = 2'b10, REPLY_TLB = 2'b11;
  - the existing ReplyRequest struct; outputs are packable into it at the top level.
- One sub-module, load_reply_age_kill: combinational age compare plus kill decision. It is instantiated once per stage.

## Test plan
- Issue idx=5, s1_dcache_ready=0 at T → reply_fast_en=1, idx=5 at T+1; no slow reply or success at T+3.
- Issue idx=3 with s2_tlb_miss=1 at T+1 → reply_slow_en=1, idx=3, reason=2'b11 at T+3.
- Issue idx=2 with s2_fwd_wait=1 and s3_mshr_full=1 → reason=2'b01 (fwd wins).
- Issue idx=1 with issue_exception=1 and s2_tlb_miss=1 → success=1, idx=1 at T+3; no slow reply.
- Loads at rob 7 and rob 9 (same dir) in S2/S3, redirect at rob 8 → rob 7 reports; rob 9 has no output. Repeat with rob 7 vs redirect_idx dir-flipped 2 (wrap) → rob 7 survives.
- Back-to-back hits on idx 0..3 over four cycles → success on four consecutive cycles with idx 0,1,2,3.
